load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the core's memory stage and the data memory.
- Accepts one access at a time: RISC-V funct3 size/sign encoding, byte address, store data.
- Issues word-aligned bus beats with byte enables and a req/ack handshake.
- Merges and sign/zero-extends load data; can split misaligned accesses into two beats.
- Replaces the purely combinational load extension path with an XLEN-parametrised, handshaked unit.

Parameters:
XLEN, 32, data width; legal values 32 or 64; NB = XLEN/8 bytes per beat, OB = log2(NB)
ADDR_W, 32, byte address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core request valid
req_ready  output  1  unit idle, can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
req_addr  input  ADDR_W  byte address
req_wdata  input  XLEN  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  XLEN  extended load data; 0 for stores and faults
resp_fault  output  1  qualifies resp_valid: illegal or misaligned access
mem_req  output  1  bus beat request, held until mem_ack
mem_we  output  1  beat is a write
mem_addr  output  ADDR_W  beat address, low OB bits always 0
mem_be  output  NB  byte enables
mem_wdata  output  XLEN  lane-aligned write data
mem_ack  input  1  beat complete; mem_rdata valid in the same cycle
mem_rdata  input  XLEN  read data

Behaviour:
- Reset (async, active-high):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_fault, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, resp_rdata = 0.
  - Reset mid-operation abandons the access; mem_req drops immediately, no response is produced.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: req_ready = 1. Request accepted on req_valid; all request fields latched. Next state is BEAT0, or RESP if the access faults.
  - BEAT0: drive beat 0; on mem_ack go to BEAT1 if the access spans two words, otherwise RESP.
  - BEAT1: drive beat 1; on mem_ack go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready = 0 in every state except IDLE.
- Size: S = 1 << funct3[1:0] bytes. Offset: off = addr[OB-1:0].
- Legality:
  - funct3 111 is illegal.
  - With XLEN=32, load funct3 011/110 and store funct3 011 are illegal.
  - Store funct3 with bit 2 set is illegal.
  - Illegal access -> resp_fault = 1, no bus beat.
- Spanning: the access spans two words when off + S > NB.
- Beat 0:
  - mem_addr = addr with low OB bits cleared.
  - mem_be = ((1<<S)-1) << off, truncated to NB bits.
  - mem_wdata = wdata << (8*off).
- Beat 1:
  - mem_addr = beat 0 address + NB, wrapping modulo 2^ADDR_W.
  - mem_be = ((1<<S)-1) >> (NB-off).
  - mem_wdata = wdata >> (8*(NB-off)).
  - For loads, mem_be still indicates the bytes used.
- Load merge:
  - Beat 0 bytes off..NB-1 are placed at result byte 0 upward; beat 1 bytes fill the remainder.
  - Result is then sign-extended (b/h/w/d) or zero-extended (bu/hu/wu) from S bytes to XLEN.
- Bus rules:
  - mem_req, mem_addr, mem_we, mem_be and mem_wdata are stable from the cycle mem_req rises until the mem_ack cycle.
  - mem_ack arriving while mem_req = 0 is ignored.
- Latency, counting the accept edge as cycle 0:
  - mem_req is high from cycle 1.
  - With zero-wait ack: aligned access gives resp_valid in cycle 2; split access in cycle 3.
  - Fault: resp_valid in cycle 1.
- resp_rdata and resp_fault hold their values until the next response; they are valid only with resp_valid.
- req_valid asserted during RESP is not accepted until the following IDLE cycle.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: spanning accesses execute as two beats, as described above; misalignment within a word needs no split and is not a fault.
- Undefined: any access with off mod S != 0 faults (resp_fault = 1, no beat, resp_valid in cycle 1); BEAT1 is never entered.

Test Plan:
- lb at 0x103, mem_rdata 0x80FF1234, ack in cycle 1 -> one beat at 0x100 with be 1000; resp_valid in cycle 2 with rdata 0xFFFFFF80.
- lhu at 0x102, same word, ack delayed 3 cycles -> request fields stable during the wait; rdata 0x000080FF; resp_valid the cycle after ack.
- With LSU_MISALIGN_SPLIT_EN: lw at 0x006, beats return 0xAABBCCDD (addr 0x004) then 0x11223344 (addr 0x008) -> rdata 0x3344AABB. Without the macro: resp_fault = 1 in cycle 1, mem_req never rises.
- sh at 0x103 with wdata 0xBEEF, split enabled -> beat 0: addr 0x100, be 1000, wdata 0xEF000000; beat 1: addr 0x104, be 0001, wdata 0x000000BE; resp_rdata 0.
- funct3 111, and load funct3 011 at XLEN=32 -> resp_fault = 1, rdata 0, no bus activity, req_ready back to 1 in cycle 2.
- reset asserted while BEAT0 is waiting for ack -> mem_req falls asynchronously, no resp_valid; a new lw at 0x200 afterwards completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundle between the load/store unit, the core's memory stage and the data
// memory. The unit sits on the slave modport; the core/memory side uses master.
interface load_store_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  // core request / response channel
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_fault;

  // data memory bus
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: takes one RISC-V sized access at a time,
// issues word-aligned bus beats with byte enables, merges and extends load data.
// Optional macro LSU_MISALIGN_SPLIT_EN: when defined, accesses that cross a
// word boundary run as two beats; when undefined, any access not aligned to
// its own size faults without touching the bus.
module load_store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int BW = 2 * NB;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state_q;
  logic              req_ready_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [OB-1:0]     off_q;
  logic              span_q;
  logic [NB-1:0]     be1_q;
  logic [XLEN-1:0]   wdata1_q;
  logic [XLEN-1:0]   data0_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [NB-1:0]     mem_be_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic              resp_valid_q;
  logic              resp_fault_q;
  logic [XLEN-1:0]   resp_rdata_q;

  // Request decode: evaluated on the incoming fields, consumed at accept.
  logic [3:0]        size_b;
  logic [OB-1:0]     off;
  logic [3:0]        off4;
  logic              illegal;
  logic              fault_d;
  logic              span_d;
  logic [BW-1:0]     be_wide;
  logic [2*XLEN-1:0] wdata_wide;

  // Load merge result for the beat completing this cycle.
  logic [XLEN-1:0]   hi_word;
  logic [XLEN-1:0]   lo_word;
  logic [XLEN-1:0]   merged;
  logic [XLEN-1:0]   rdata_d;

  // Sign- or zero-extend the low 2^f3[1:0] bytes of d to the full width.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] top;
    int unsigned     nbits;
    nbits = 32'd8 << f3[1:0];
    keep  = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    top   = keep & ~(keep >> 1);
    if (!f3[2] && (|(d & top))) return d | ~keep;
    return d & keep;
  endfunction

  // Legality, alignment and lane placement of the request on the input port.
  always_comb begin
    size_b     = 4'd1 << bus.req_funct3[1:0];
    off        = bus.req_addr[OB-1:0];
    off4       = 4'(off);
    illegal    = (bus.req_funct3 == 3'b111)
               || (bus.req_we && bus.req_funct3[2])
               || ((XLEN == 32) && ((bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110)));
    be_wide    = ((BW'(1) << size_b) - BW'(1)) << off;
    wdata_wide = {{XLEN{1'b0}}, bus.req_wdata} << {off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
    fault_d    = illegal;
    span_d     = ({1'b0, off4} + {1'b0, size_b}) > 5'(NB);
`else
    // Without splitting, only size-aligned accesses are served; those never cross a word.
    fault_d    = illegal || (|(off4 & (size_b - 4'd1)));
    span_d     = 1'b0;
`endif
  end

  // Byte-align the returned data: beat 0 supplies the low bytes, beat 1 the rest.
  always_comb begin
    hi_word = (state_q == BEAT1) ? bus.mem_rdata : '0;
    lo_word = (state_q == BEAT1) ? data0_q : bus.mem_rdata;
    merged  = XLEN'({hi_word, lo_word} >> {off_q, 3'b000});
    rdata_d = we_q ? '0 : extend(merged, f3_q);
  end

  // Control FSM with registered bus and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      span_q       <= 1'b0;
      be1_q        <= '0;
      wdata1_q     <= '0;
      data0_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= bus.req_we;
            f3_q        <= bus.req_funct3;
            off_q       <= off;
            span_q      <= span_d;
            be1_q       <= be_wide[BW-1:NB];
            wdata1_q    <= wdata_wide[2*XLEN-1:XLEN];
            if (fault_d) begin
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= '0;
              state_q      <= RESP;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.req_addr[ADDR_W-1:OB], {OB{1'b0}}};
              mem_be_q    <= be_wide[NB-1:0];
              mem_wdata_q <= wdata_wide[XLEN-1:0];
              state_q     <= BEAT0;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (bus.mem_ack) begin
            if ((state_q == BEAT0) && span_q) begin
              // Second beat goes to the next word; address wraps at the top.
              data0_q     <= bus.mem_rdata;
              mem_addr_q  <= mem_addr_q + ADDR_W'(NB);
              mem_be_q    <= be1_q;
              mem_wdata_q <= wdata1_q;
              state_q     <= BEAT1;
            end else begin
              mem_req_q    <= 1'b0;
              mem_we_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b0;
              resp_rdata_q <= rdata_d;
              state_q      <= RESP;
            end
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN=32). A byte-addressed memory
// model supplies beats; expected bus beats, response timing and load values
// are derived from byte-level rules and compared every cycle at negedge.
module tb_load_store_unit;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int NB     = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem_b [0:255];

  int checks = 0;
  int errors = 0;

  // cycle-by-cycle expectations, written by the driver just after posedge
  logic        chk_en         = 1'b0;
  logic        exp_in_reset   = 1'b0;
  logic        exp_ready      = 1'b1;
  logic        exp_mem_req    = 1'b0;
  logic        exp_we         = 1'b0;
  logic        exp_resp_valid = 1'b0;
  logic        exp_fault      = 1'b0;
  logic [31:0] exp_rdata      = '0;
  logic [31:0] eb_addr [2];
  logic [3:0]  eb_be   [2];
  logic [31:0] eb_wd   [2];
  logic        cur_beat       = 1'b0;

  // hand-computed literal expectations for directed cases
  logic        pin_rdata_en = 1'b0;
  logic [31:0] pin_rdata    = '0;
  logic        pin_beat_en  = 1'b0;
  logic [31:0] pin_addr [2];
  logic [3:0]  pin_be   [2];
  logic [31:0] pin_wd   [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // the single compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("mem_req", 64'(bus.mem_req), 64'(exp_mem_req));
      chk("resp_valid", 64'(bus.resp_valid), 64'(exp_resp_valid));
      if (exp_in_reset) begin
        chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_mem_be", 64'(bus.mem_be), 64'(0));
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'(0));
        chk("rst_resp_fault", 64'(bus.resp_fault), 64'(0));
      end
      if (exp_mem_req) begin
        chk("mem_we", 64'(bus.mem_we), 64'(exp_we));
        chk("mem_addr", 64'(bus.mem_addr), 64'(eb_addr[cur_beat]));
        chk("mem_be", 64'(bus.mem_be), 64'(eb_be[cur_beat]));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(eb_wd[cur_beat]));
        if (pin_beat_en) begin
          chk("pin_mem_addr", 64'(bus.mem_addr), 64'(pin_addr[cur_beat]));
          chk("pin_mem_be", 64'(bus.mem_be), 64'(pin_be[cur_beat]));
          chk("pin_mem_wdata", 64'(bus.mem_wdata), 64'(pin_wd[cur_beat]));
        end
      end
      if (exp_resp_valid) begin
        chk("resp_fault", 64'(bus.resp_fault), 64'(exp_fault));
        chk("resp_rdata", 64'(bus.resp_rdata), 64'(exp_rdata));
        if (pin_rdata_en) chk("pin_resp_rdata", 64'(bus.resp_rdata), 64'(pin_rdata));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] wa);
    logic [31:0] w;
    for (int i = 0; i < NB; i++) w[8*i +: 8] = mem_b[8'(wa + 32'(i))];
    return w;
  endfunction

  // Byte-level reference: which bytes each beat touches, what lands on which
  // lane, and the value a load must return.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic flt, output int nb,
                       output logic [31:0] rd);
    int          sz;
    int          off;
    logic        illegal;
    logic        mis;
    logic [31:0] v;
    sz  = 1 << f3[1:0];
    off = int'(a[1:0]);
    illegal = (f3 == 3'b111) || (we && f3[2]) || (f3[1:0] == 2'b11) || (f3 == 3'b110);
`ifdef LSU_MISALIGN_SPLIT_EN
    mis = 1'b0;
`else
    mis = (int'(a[2:0]) % sz) != 0;
`endif
    flt = illegal || mis;
    nb  = flt ? 0 : ((off + sz > NB) ? 2 : 1);
    eb_addr[0] = {a[31:2], 2'b00};
    eb_addr[1] = eb_addr[0] + 32'd4;
    eb_be[0] = '0; eb_be[1] = '0;
    eb_wd[0] = '0; eb_wd[1] = '0;
    if (!flt) begin
      for (int i = 0; i < sz; i++) begin
        if (off + i < NB) eb_be[0][off + i] = 1'b1;
        else              eb_be[1][off + i - NB] = 1'b1;
      end
      for (int j = 0; j < NB; j++) begin
        if (j >= off) eb_wd[0][8*j +: 8] = wd[8*(j - off) +: 8];
        else          eb_wd[1][8*j +: 8] = wd[8*(j + NB - off) +: 8];
      end
    end
    v = '0;
    if (!flt && !we) begin
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_b[8'(a + 32'(i))];
      if (!f3[2] && sz < 4 && v[8*sz - 1]) for (int b = 8*sz; b < 32; b++) v[b] = 1'b1;
    end
    rd = v;
  endtask

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic junk_req();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.req_valid = 1'b0;
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = $urandom;
      step();
    end
    bus.mem_ack = 1'b0;
  endtask

  // One complete access; entered and left in an IDLE cycle just after posedge.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int d0, input int d1, input bit early);
    logic        flt;
    int          nb;
    logic [31:0] rd;
    model(we, f3, a, wd, flt, nb, rd);
    present(we, f3, a, wd);
    bus.mem_ack   = 1'($urandom);
    bus.mem_rdata = $urandom;
    step();
    junk_req();
    bus.mem_ack = 1'b0;
    exp_ready   = 1'b0;
    exp_we      = we;
    for (int k = 0; k < nb; k++) begin
      exp_mem_req = 1'b1;
      cur_beat    = 1'(k);
      repeat ((k == 0) ? d0 : d1) begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        step();
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = we ? $urandom : word_at(eb_addr[k]);
      step();
      if (we) for (int j = 0; j < NB; j++)
        if (eb_be[k][j]) mem_b[8'(eb_addr[k] + 32'(j))] = eb_wd[k][8*j +: 8];
      bus.mem_ack = 1'b0;
    end
    exp_mem_req    = 1'b0;
    exp_resp_valid = 1'b1;
    exp_fault      = flt;
    exp_rdata      = rd;
    bus.mem_ack    = 1'($urandom);
    if (early) present(we, f3, a, wd);
    step();
    exp_resp_valid = 1'b0;
    exp_ready      = 1'b1;
    bus.mem_ack    = 1'b0;
    pin_rdata_en   = 1'b0;
    pin_beat_en    = 1'b0;
  endtask

  initial begin
    logic        flt;
    int          nb;
    logic [31:0] rd;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    bit          r_early;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);

    // reset state
    #2;
    reset        = 1'b1;
    exp_in_reset = 1'b1;
    chk_en       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    exp_in_reset = 1'b0;

    // lb at 0x103, zero-wait ack
    mem_b[8'h00] = 8'h34; mem_b[8'h01] = 8'h12; mem_b[8'h02] = 8'hFF; mem_b[8'h03] = 8'h80;
    pin_rdata_en = 1'b1; pin_rdata = 32'hFFFF_FF80;
    pin_beat_en = 1'b1; pin_addr[0] = 32'h100; pin_be[0] = 4'b1000; pin_wd[0] = 32'h0;
    run(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 1'b0);

    // lhu at 0x102, ack after 3 wait cycles
    pin_rdata_en = 1'b1; pin_rdata = 32'h0000_80FF;
    pin_beat_en = 1'b1; pin_addr[0] = 32'h100; pin_be[0] = 4'b1100; pin_wd[0] = 32'h0;
    run(1'b0, 3'b101, 32'h102, 32'h0, 3, 0, 1'b0);

    // lw at 0x006 crossing 0x004/0x008
    mem_b[8'h04] = 8'hDD; mem_b[8'h05] = 8'hCC; mem_b[8'h06] = 8'hBB; mem_b[8'h07] = 8'hAA;
    mem_b[8'h08] = 8'h44; mem_b[8'h09] = 8'h33; mem_b[8'h0A] = 8'h22; mem_b[8'h0B] = 8'h11;
    pin_rdata_en = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
    pin_rdata = 32'h3344_AABB;
    pin_beat_en = 1'b1;
    pin_addr[0] = 32'h004; pin_be[0] = 4'b1100; pin_wd[0] = 32'h0;
    pin_addr[1] = 32'h008; pin_be[1] = 4'b0011; pin_wd[1] = 32'h0;
`else
    pin_rdata = 32'h0;
`endif
    run(1'b0, 3'b010, 32'h006, 32'h0, 1, 2, 1'b0);

    // sh at 0x103 with 0xBEEF
    pin_rdata_en = 1'b1; pin_rdata = 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
    pin_beat_en = 1'b1;
    pin_addr[0] = 32'h100; pin_be[0] = 4'b1000; pin_wd[0] = 32'hEF00_0000;
    pin_addr[1] = 32'h104; pin_be[1] = 4'b0001; pin_wd[1] = 32'h0000_00BE;
`endif
    run(1'b1, 3'b001, 32'h103, 32'h0000_BEEF, 0, 0, 1'b0);

    // illegal encodings; the first holds req_valid through RESP
    pin_rdata_en = 1'b1; pin_rdata = 32'h0;
    run(1'b0, 3'b111, 32'h040, 32'h0, 0, 0, 1'b1);
    pin_rdata_en = 1'b1; pin_rdata = 32'h0;
    run(1'b0, 3'b111, 32'h040, 32'h0, 0, 0, 1'b0);
    pin_rdata_en = 1'b1; pin_rdata = 32'h0;
    run(1'b0, 3'b011, 32'h040, 32'h0, 0, 0, 1'b0);
    idle(2);

    // reset while beat 0 waits for ack
    model(1'b0, 3'b010, 32'h200, 32'h0, flt, nb, rd);
    present(1'b0, 3'b010, 32'h200, 32'h0);
    step();
    junk_req();
    bus.mem_ack = 1'b0;
    exp_ready   = 1'b0;
    exp_we      = 1'b0;
    exp_mem_req = 1'b1;
    cur_beat    = 1'b0;
    step();
    #1;
    reset        = 1'b1;
    exp_mem_req  = 1'b0;
    exp_ready    = 1'b1;
    exp_in_reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    exp_in_reset = 1'b0;
    idle(2);
    run(1'b0, 3'b010, 32'h200, 32'h0, 1, 0, 1'b0);

    // randomized traffic
    r_early = 1'b0;
    r_we = 1'b0; r_f3 = '0; r_a = '0; r_wd = '0;
    for (int t = 0; t < 400; t++) begin
      if (!r_early) begin
        r_we = 1'($urandom);
        r_f3 = 3'($urandom);
        r_wd = $urandom;
        if ($urandom_range(0, 7) == 0) r_a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        else                           r_a = $urandom;
      end
      r_early = ($urandom_range(0, 5) == 0);
      run(r_we, r_f3, r_a, r_wd, $urandom_range(0, 3), $urandom_range(0, 3), r_early);
      if (!r_early && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
